// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the seq_gen serial pattern transmitter.
package seq_gen_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

   // Fibonacci feedback mask on a right-shifting register for x^16+x^14+x^13+x^11+1:
   // the new MSB is the XOR of state bits 0, 2, 3 and 5.
   localparam logic [15:0] PRBS16_TAPS  = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [15:0] prbs16_step(input logic [15:0] s);
      return {^(s & PRBS16_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Word handshake, filler control and serial output of seq_gen.
interface seq_gen_if #(
   parameter int WIDTH = 16,
   parameter int GAP_W = 4
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic [GAP_W-1:0] gap_len;
   logic             filler_en;
   logic             out;
   logic             out_active;
   logic             last_bit;

   modport master (
      output data_in, data_valid, gap_len, filler_en,
      input  data_ready, out, out_active, last_bit
   );

   modport slave (
      input  data_in, data_valid, gap_len, filler_en,
      output data_ready, out, out_active, last_bit
   );
endinterface

// File: rtl/seq_gen_prbs16.sv
// Free-running PRBS16 generator; advances one step per clk, held at SEED in reset.
module prbs16
   import seq_gen_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic clk,
   input  logic rst,
   output logic bit0
);
   logic [15:0] state;

   always_ff @(posedge clk) begin
      if (rst) state <= SEED;
      else     state <= prbs16_step(state);
   end

   assign bit0 = state[0];
endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: words shifted out LSB-first, programmable idle gap,
// optional PRBS16 filler on idle cycles.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int          WIDTH = 16,
   parameter int          GAP_W = 4,
   parameter logic [15:0] SEED  = DEFAULT_SEED
) (
   input logic      clk,
   input logic      rst,
   seq_gen_if.slave bus
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [GAP_W-1:0] gap_q, gap_cnt_q;
   logic [CW-1:0]    bit_cnt_q;
   logic             out_q, act_q, last_q;
   logic             lfsr_bit;
   logic             ready, accept, last_cycle;

   prbs16 #(.SEED(SEED)) u_prbs (
      .clk  (clk),
      .rst  (rst),
      .bit0 (lfsr_bit)
   );

   always_comb begin
      state_d    = state_q;
      ready      = 1'b0;
      last_cycle = (state_q == SHIFT) && (bit_cnt_q == LAST);
      case (state_q)
         IDLE:    ready = 1'b1;
         SHIFT:   ready = last_cycle && (gap_q == '0);
         default: ready = 1'b0;
      endcase
      if (rst) ready = 1'b0;
      accept = bus.data_valid && ready;
      case (state_q)
         IDLE: if (accept) state_d = SHIFT;
         SHIFT: begin
            if (last_cycle) begin
               if (accept)             state_d = SHIFT;
               else if (gap_q == '0)   state_d = IDLE;
               else                    state_d = GAP;
            end
         end
         // gap_cnt_q is loaded non-zero on entry, so <=1 ends the gap without wrapping
         GAP: if (gap_cnt_q <= GAP_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.data_ready = ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         out_q     <= 1'b0;
         act_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            bit_cnt_q <= '0;
            out_q     <= bus.data_in[0];
            act_q     <= 1'b1;
            last_q    <= 1'b0;
         end else if ((state_q == SHIFT) && !last_cycle) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            out_q     <= shreg_q[0];
            act_q     <= 1'b1;
            last_q    <= (bit_cnt_q == PRE_LAST);
         end else begin
            out_q  <= bus.filler_en & lfsr_bit;
            act_q  <= 1'b0;
            last_q <= 1'b0;
         end
      end
   end

   // Payload and gap datapath: only meaningful once loaded by an accept, so no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         shreg_q <= bus.data_in >> 1;
         gap_q   <= bus.gap_len;
      end else if ((state_q == SHIFT) && !last_cycle) begin
         shreg_q <= shreg_q >> 1;
      end
      if (last_cycle && !accept)
         gap_cnt_q <= gap_q;
      else if ((state_q == GAP) && (gap_cnt_q != '0))
         gap_cnt_q <= gap_cnt_q - 1'b1;
   end

   assign bus.out        = out_q;
   assign bus.out_active = act_q;
   assign bus.last_bit   = last_q;
endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: reset, single/back-to-back words, gaps, PRBS filler, reset mid-word.
module tb_seq_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic [15:0] m;

   always #5 clk = ~clk;

   seq_gen_if #(.WIDTH(16), .GAP_W(4)) bus ();

   seq_gen #(.WIDTH(16), .GAP_W(4), .SEED(16'hACE1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Independent PRBS16 reference: new MSB = s0^s2^s3^s5, shift right
   function automatic logic [15:0] ref_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   // Called in cycle k+1 after an accept edge; returns in the bit-15 cycle
   task automatic check_word(input logic [15:0] w, input logic exp_ready_last);
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("bit%0d", i), bus.out, w[i]);
         chk($sformatf("act%0d", i), bus.out_active, 1'b1);
         chk($sformatf("last%0d", i), bus.last_bit, (i == 15));
         if (i == 15) chk("ready_at_last", bus.data_ready, exp_ready_last);
         else         tick();
      end
   endtask

   task automatic check_gap(input int n);
      for (int j = 0; j < n; j++) begin
         tick();
         chk($sformatf("gap_ready%0d", j), bus.data_ready, 1'b0);
         chk($sformatf("gap_act%0d", j), bus.out_active, 1'b0);
         chk($sformatf("gap_out%0d", j), bus.out, 1'b0);
      end
      tick();
      chk("gap_end_ready", bus.data_ready, 1'b1);
   endtask

   initial begin
      bus.data_in    = '0;
      bus.data_valid = 1'b0;
      bus.gap_len    = '0;
      bus.filler_en  = 1'b0;

      // 1. reset, with a handshake attempt that must be ignored
      bus.data_valid = 1'b1;
      bus.data_in    = 16'hFFFF;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_out", bus.out, 1'b0);
         chk("rst_act", bus.out_active, 1'b0);
         chk("rst_ready", bus.data_ready, 1'b0);
      end
      bus.data_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("post_rst_ready", bus.data_ready, 1'b1);
      chk("post_rst_act", bus.out_active, 1'b0);

      // 2. single word 16'hABCD, gap 0
      bus.data_in = 16'hABCD; bus.gap_len = 4'd0; bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0; bus.data_in = 16'h0000;
      check_word(16'hABCD, 1'b1);
      tick();
      chk("w1_idle_out", bus.out, 1'b0);
      chk("w1_idle_act", bus.out_active, 1'b0);
      chk("w1_idle_ready", bus.data_ready, 1'b1);

      // 3. back-to-back 16'h0001 then 16'h8000 with valid held
      bus.data_in = 16'h0001; bus.data_valid = 1'b1;
      tick();
      bus.data_in = 16'h8000;
      check_word(16'h0001, 1'b1);
      tick();
      bus.data_valid = 1'b0;
      check_word(16'h8000, 1'b1);
      tick();
      chk("b2b_end_act", bus.out_active, 1'b0);

      // 4. gaps of 3 and 15 cycles; gap_len changes after accept must not matter
      bus.data_in = 16'hFFFF; bus.gap_len = 4'd3; bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0; bus.gap_len = 4'd9;
      check_word(16'hFFFF, 1'b0);
      check_gap(3);
      bus.gap_len = 4'd15; bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0; bus.gap_len = 4'd1;
      check_word(16'hFFFF, 1'b0);
      check_gap(15);

      // 5. PRBS filler from SEED, then a payload word with filler still on
      rst = 1'b1;
      tick();
      tick();
      bus.filler_en = 1'b1;
      rst = 1'b0;
      m = 16'hACE1;
      for (int c = 0; c < 40; c++) begin
         tick();
         chk($sformatf("prbs%0d", c), bus.out, m[0]);
         m = ref_step(m);
      end
      bus.data_in = 16'h00FF; bus.gap_len = 4'd0; bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      check_word(16'h00FF, 1'b1);
      bus.filler_en = 1'b0;
      tick();

      // 6. reset during bit 7 of 16'h5A5A, then a fresh word
      bus.data_in = 16'h5A5A; bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("pre_rst_bit%0d", i), bus.out, 16'h5A5A >> i & 16'h1);
         if (i < 7) tick();
      end
      rst = 1'b1;
      tick();
      chk("midrst_out", bus.out, 1'b0);
      chk("midrst_act", bus.out_active, 1'b0);
      chk("midrst_ready", bus.data_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("after_rst_ready", bus.data_ready, 1'b1);
      bus.data_in = 16'h00FF; bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
      check_word(16'h00FF, 1'b1);
      tick();
      chk("final_act", bus.out_active, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
